dm_resp: RTL and testbench
==========================

# dm_resp

Data-memory responder for the MIPS core: the memory-side end of the MemRead/MemWrite/MemOpType/MemDataExtType control bundle driven by the instruction decoder. It accepts one word or byte access at a time, holds the pipeline via `stall` for a configurable access latency, and returns load data already zero- or sign-extended. Byte stores are performed as an internal read-modify-write on a word-organised array.

## Interface
Parameters:
- ADDR_WIDTH, 10, word-address bits; array depth = 2^ADDR_WIDTH words.
- LATENCY, 2, array wait cycles per access; legal range 1..15.

Ports:
- Clocking: one clock; reset is asynchronous and active-high (`clk`, `rst`).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- MemRead  in  1  load request.
- MemWrite  in  1  store request; has priority over MemRead.
- MemOpType  in  1  0 = word access, 1 = byte access.
- MemDataExtType  in  1  byte-load extension: 0 = zero-extend, 1 = sign-extend; ignored for word access and stores.
- addr  in  32  byte address from the ALU.
- wdata  in  32  store data; byte stores use wdata[7:0].
- rdata  out  32  load result; valid only in the DONE cycle.
- stall  out  1  freezes the pipeline while an access is in progress.
- misalign  out  1  one-cycle pulse in DONE for a word access with addr[1:0] != 0.

## Operation
- Word index = addr[ADDR_WIDTH+1:2]; upper address bits ignored. Byte lane = addr[1:0], little-endian (lane 0 = bits 7:0).
- States: IDLE, WAIT, RMW, DONE.
- IDLE: req = MemRead | MemWrite. On req, latch op, ext, addr, wdata, then go to WAIT with counter = LATENCY-1. Inputs are ignored until the block returns to IDLE.
- WAIT: decrement the counter each cycle. When the counter reaches 0:
  - word store: commit wdata to the array, go to DONE.
  - byte store: capture the addressed word, go to RMW.
  - load: capture the addressed word, go to DONE.
- RMW: write back the captured word with the addressed lane replaced by the latched wdata[7:0]; the other three bytes are unchanged. Go to DONE.
- DONE: stall = 0.
  - Load result: word load gives the full word; byte load gives the selected byte, extended per the latched ext.
  - Stores: rdata = 0.
  - Next state is always IDLE.
- Both MemRead and MemWrite high: treated as a store; no load data.
- Misaligned word access: addr[1:0] ignored (aligned word used), misalign = 1 in DONE. Byte accesses never flag misalign.

## Timing
- stall = (IDLE & req) | WAIT | RMW; combinational from state and request inputs.
- Stall cycles per access:
  - word load/store: 1 + LATENCY.
  - byte load: 1 + LATENCY.
  - byte store: 2 + LATENCY.
- DONE lasts exactly one cycle; the pipeline advances on the edge ending DONE. A request seen in the following IDLE cycle is a new access.
- Back-to-back accesses: one IDLE cycle always separates DONE from the next WAIT.
- Reset (any cycle, any state):
  - state = IDLE, counter = 0, rdata = 0, misalign = 0, latches = 0.
  - stall follows req combinationally.
  - A store not yet committed (reset before its commit edge) is dropped.
  - The array is not cleared.
- Store → load to the same word: the load returns the committed data, because the store commits before DONE.

## Test plan
- LATENCY=2: sw 0xDEADBEEF to addr 0x10, then lw from 0x10 → stall high 3 cycles for each access; rdata = 0xDEADBEEF in the load's DONE cycle.
- Word 0x11228033 at 0x20: lb 0x21 (ext=1) → 0xFFFFFF80; lbu 0x21 (ext=0) → 0x00000080; lb 0x22 (ext=1) → 0x00000022.
- Word 0xAABBCCDD at 0x30, sb wdata=0x12345677 at 0x32 → stall 4 cycles; subsequent lw 0x30 → 0xAA77CCDD.
- lw at 0x41 after sw 0xCAFEF00D to 0x40 → rdata 0xCAFEF00D, misalign = 1 for exactly one cycle.
- MemRead=MemWrite=1, wdata 0x5, addr 0x50 → rdata 0 in DONE; later lw 0x50 → 0x00000005.
- Word at 0x60 preset to 0x0; sw 0xFFFFFFFF to 0x60 with rst pulsed in the first WAIT cycle → state IDLE, rdata 0, stall low with no request; lw 0x60 → 0x00000000.

Source files
------------

// File: rtl/dm_resp.sv
// Data-memory responder: one word/byte access at a time, pipeline stall for the
// configured latency, extended load data, byte stores via read-modify-write.
module dm_resp #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemOpType,
  input  logic        MemDataExtType,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RMW, S_DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  store_q, store_d;
  logic                  byte_q, byte_d;
  logic                  ext_q, ext_d;
  logic [ADDR_WIDTH+1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           word_q, word_d;

  logic [31:0]           mem [2**ADDR_WIDTH];
  logic                  mem_we;
  logic [31:0]           mem_wd;

  logic                  req;
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            lane;
  logic [7:0]            sel_byte;
  logic [31:0]           merged;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];

  always_comb begin
    req      = MemRead | MemWrite;
    idx      = addr_q[ADDR_WIDTH+1:2];
    lane     = addr_q[1:0];
    sel_byte = word_q[{lane, 3'b000} +: 8];
    merged   = word_q;
    merged[{lane, 3'b000} +: 8] = wdata_q[7:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    store_d  = store_q;
    byte_d   = byte_q;
    ext_d    = ext_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    word_d   = word_q;
    mem_we   = 1'b0;
    mem_wd   = '0;
    stall    = 1'b0;
    rdata    = '0;
    misalign = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          stall   = 1'b1;
          store_d = MemWrite;
          byte_d  = MemOpType;
          ext_d   = MemDataExtType;
          addr_d  = addr[ADDR_WIDTH+1:0];
          wdata_d = wdata;
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (cnt_q == 4'd0) begin
          if (store_q && !byte_q) begin
            mem_we  = 1'b1;
            mem_wd  = wdata_q;
            state_d = S_DONE;
          end else begin
            word_d  = mem[idx];
            state_d = store_q ? S_RMW : S_DONE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RMW: begin
        stall   = 1'b1;
        mem_we  = 1'b1;
        mem_wd  = merged;
        state_d = S_DONE;
      end
      S_DONE: begin
        misalign = !byte_q && (lane != 2'd0);
        if (!store_q) begin
          if (!byte_q)    rdata = word_q;
          else if (ext_q) rdata = {{24{sel_byte[7]}}, sel_byte};
          else            rdata = {24'd0, sel_byte};
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      store_q <= 1'b0;
      byte_q  <= 1'b0;
      ext_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      store_q <= store_d;
      byte_q  <= byte_d;
      ext_q   <= ext_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
    end
  end

  // Array is never cleared; a commit coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[idx] <= mem_wd;
  end

endmodule

// File: tb/tb_dm_resp.sv
// Randomized self-checking bench for dm_resp against a word-array reference model.
module tb_dm_resp;
  localparam int AW  = 10;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite, MemOpType, MemDataExtType;
  logic [31:0] addr, wdata, rdata;
  logic        stall, misalign;

  dm_resp #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemOpType(MemOpType), .MemDataExtType(MemDataExtType),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [2**AW];
  logic        mon_en = 1'b0;
  logic        exp_stall = 1'b0, exp_done = 1'b0, exp_mis = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic [31:0] last_rdata = '0;
  int          stall_cycles = 0;
  int          mis_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("stall", {31'd0, stall}, {31'd0, exp_stall});
      check("misalign", {31'd0, misalign}, {31'd0, exp_done & exp_mis});
      if (stall) stall_cycles++;
      if (misalign) mis_cycles++;
      if (exp_done) begin
        check("rdata", rdata, exp_rdata);
        last_rdata = rdata;
      end
    end
  end

  // Called #1 after a rising edge with the DUT idle.
  task automatic access(input bit rd, input bit wr, input bit byt, input bit ext,
                        input logic [31:0] a, input logic [31:0] wd);
    int n;
    logic [AW-1:0] idx;
    logic [31:0]   w;
    logic [7:0]    b;
    int            lane;
    idx  = a[AW+1:2];
    lane = int'(a[1:0]);
    n    = (wr && byt) ? 2 + LAT : 1 + LAT;
    w    = model[idx];
    b    = w[lane*8 +: 8];
    if (wr) begin
      exp_rdata = '0;
      if (byt) begin
        w[lane*8 +: 8] = wd[7:0];
        model[idx] = w;
      end else begin
        model[idx] = wd;
      end
    end else if (!byt) exp_rdata = w;
    else if (ext)      exp_rdata = {{24{b[7]}}, b};
    else               exp_rdata = {24'd0, b};
    exp_mis = !byt && (a[1:0] != 2'd0);

    stall_cycles = 0;
    mis_cycles = 0;
    MemRead = rd; MemWrite = wr; MemOpType = byt; MemDataExtType = ext;
    addr = a; wdata = wd;
    exp_stall = 1'b1; exp_done = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == n - 1) begin exp_stall = 1'b0; exp_done = 1'b1; end
      MemRead = 1'($urandom); MemWrite = 1'($urandom);
      MemOpType = 1'($urandom); MemDataExtType = 1'($urandom);
      addr = $urandom; wdata = $urandom;
    end
    @(posedge clk); #1;
    exp_done = 1'b0; exp_stall = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0; MemOpType = 1'b0; MemDataExtType = 1'b0;
    addr = '0; wdata = '0;
  endtask

  initial begin
    logic [31:0] ra;
    bit rd, wr;
    rst = 1'b1;
    MemRead = 1'b0; MemWrite = 1'b0; MemOpType = 1'b0; MemDataExtType = 1'b0;
    addr = '0; wdata = '0;
    #3;
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_misalign", {31'd0, misalign}, 32'd0);
    MemRead = 1'b1; #1;
    check("reset_stall_follows_req", {31'd0, stall}, 32'd1);
    MemRead = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 64; i++) access(0, 1, 0, 0, 32'(i * 4), 32'd0);

    access(0, 1, 0, 0, 32'h10, 32'hDEADBEEF);
    check("sw_stall_cycles", 32'(stall_cycles), 32'd3);
    access(1, 0, 0, 0, 32'h10, 32'h0);
    check("lw_10", last_rdata, 32'hDEADBEEF);
    check("lw_stall_cycles", 32'(stall_cycles), 32'd3);

    access(0, 1, 0, 0, 32'h20, 32'h11228033);
    access(1, 0, 1, 1, 32'h21, 32'h0);
    check("lb_21", last_rdata, 32'hFFFFFF80);
    check("lb_stall_cycles", 32'(stall_cycles), 32'd3);
    access(1, 0, 1, 0, 32'h21, 32'h0);
    check("lbu_21", last_rdata, 32'h00000080);
    access(1, 0, 1, 1, 32'h22, 32'h0);
    check("lb_22", last_rdata, 32'h00000022);

    access(0, 1, 0, 0, 32'h30, 32'hAABBCCDD);
    access(0, 1, 1, 0, 32'h32, 32'h12345677);
    check("sb_stall_cycles", 32'(stall_cycles), 32'd4);
    access(1, 0, 0, 0, 32'h30, 32'h0);
    check("lw_30_after_sb", last_rdata, 32'hAA77CCDD);

    access(0, 1, 0, 0, 32'h40, 32'hCAFEF00D);
    access(1, 0, 0, 0, 32'h41, 32'h0);
    check("lw_41", last_rdata, 32'hCAFEF00D);
    check("misalign_cycles", 32'(mis_cycles), 32'd1);

    access(1, 1, 0, 0, 32'h50, 32'h5);
    check("rw_both_rdata", last_rdata, 32'h0);
    access(1, 0, 0, 0, 32'h50, 32'h0);
    check("lw_50", last_rdata, 32'h00000005);

    // Store to 0x60 aborted by reset during its first WAIT cycle.
    MemWrite = 1'b1; addr = 32'h60; wdata = 32'hFFFFFFFF;
    exp_stall = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    MemWrite = 1'b0; addr = '0; wdata = '0;
    exp_stall = 1'b0;
    #1;
    check("midrst_stall", {31'd0, stall}, 32'd0);
    check("midrst_rdata", rdata, 32'd0);
    check("midrst_misalign", {31'd0, misalign}, 32'd0);
    #1; MemWrite = 1'b1; #1;
    check("midrst_stall_follows_req", {31'd0, stall}, 32'd1);
    MemWrite = 1'b0;
    #2; rst = 1'b0;
    @(posedge clk); #1;
    access(1, 0, 0, 0, 32'h60, 32'h0);
    check("lw_60_after_reset", last_rdata, 32'h0);
    check("lw_60_stall_cycles", 32'(stall_cycles), 32'd3);

    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      ra[AW+1:8] = '0;
      wr = 1'($urandom);
      rd = 1'($urandom) | ~wr;
      access(rd, wr, 1'($urandom), 1'($urandom), ra, $urandom);
      if (($urandom % 8) == 0) begin @(posedge clk); #1; end
    end

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
